// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// instruction_fetch_stage : PC, instruction-memory address and IF/ID register
//   with stall, branch/jump redirect, syscall halt and fetch counting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_SYSCALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_count;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_is_syscall;

  // Branch beats jump when both fire; targets are forced word-aligned.
  assign w_redirect   = branch_taken | jump;
  assign w_target     = branch_taken ? {branch_target[31:2], 2'b00}
                                     : {jump_target[31:2], 2'b00};
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_is_syscall = HALT_ON_SYSCALL
                        && (imem_instruction[31:26] == 6'h00)
                        && (imem_instruction[5:0] == 6'h0C);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
      r_count    <= 32'h0;
    end else if (w_redirect) begin
      // A redirect also revives a halted front end: the syscall was wrong-path.
      r_state    <= ST_RUN;
      r_pc       <= w_target;
      r_instr    <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (stall) begin
      r_state <= r_state;
    end else if (r_state == ST_HALTED) begin
      r_instr <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      r_pc       <= w_pc_plus4;
      r_instr    <= imem_instruction;
      r_pc_plus4 <= w_pc_plus4;
      r_valid    <= 1'b1;
      r_count    <= r_count + 32'd1;
      if (w_is_syscall) begin
        r_state <= ST_HALTED;
      end
    end
  end

  assign imem_pc           = r_pc;
  assign if_id_instruction = r_instr;
  assign if_id_pc_plus4    = r_pc_plus4;
  assign if_id_valid       = r_valid;
  assign halted            = (r_state == ST_HALTED);
  assign fetch_count       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// tb_instruction_fetch_stage : scoreboard bench for instruction_fetch_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic        r_force_sys;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
    logic        h;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    logic        rn;
    logic        st;
    logic        bt;
    logic        jp;
    logic        ov;
    logic [31:0] btg;
    logic [31:0] jtg;
    exp_t        e;
  } stim_t;

  exp_t sb[$];

  instruction_fetch_stage #(
    .RESET_PC       (32'h0000_0000),
    .HALT_ON_SYSCALL(1'b1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid),
    .halted           (halted),
    .fetch_count      (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: word k holds 0x20080001 + k*0x00010001; address 0x10 is a syscall.
  function automatic logic [31:0] prog(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    return 32'h2008_0001 + idx * 32'h0001_0001;
  endfunction

  always_comb begin
    imem_instruction = prog(imem_pc);
    if (r_force_sys || imem_pc == 32'h10) imem_instruction = 32'h0000_000C;
  end

  function automatic stim_t mk(input logic rn, st, bt, jp, ov,
                               input logic [31:0] btg, jtg,
                               input logic [31:0] pc, ins, p4,
                               input logic v, h, input logic [31:0] cnt);
    stim_t s;
    s.rn = rn; s.st = st; s.bt = bt; s.jp = jp; s.ov = ov;
    s.btg = btg; s.jtg = jtg;
    s.e.pc = pc; s.e.ins = ins; s.e.p4 = p4; s.e.v = v; s.e.h = h; s.e.cnt = cnt;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst_n         = s.rn;
    stall         = s.st;
    branch_taken  = s.bt;
    jump          = s.jp;
    r_force_sys   = s.ov;
    branch_target = s.btg;
    jump_target   = s.jtg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.pc = imem_pc; o.ins = if_id_instruction; o.p4 = if_id_pc_plus4;
    o.v = if_id_valid; o.h = halted; o.cnt = fetch_count;
    return o;
  endfunction

  task automatic test_reset();
    stim_t s[$];
    exp_t o, e;
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'd0));
    s.push_back(mk(0, 1, 1, 1, 1, 32'h40, 32'h80, 32'h0, 32'h0, 32'h0, 0, 0, 32'd0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].e); tick();
      o = observe(); e = sb.pop_front(); total++;
      if (o !== e) $display("FAIL reset[%0d]: got pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d want pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d",
                            i, o.pc, o.ins, o.p4, o.v, o.h, o.cnt, e.pc, e.ins, e.p4, e.v, e.h, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_sequential();
    stim_t s[$];
    exp_t o, e;
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h4, 32'h2008_0001, 32'h4, 1, 0, 32'd1));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h8, 32'h2009_0002, 32'h8, 1, 0, 32'd2));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].e); tick();
      o = observe(); e = sb.pop_front(); total++;
      if (o !== e) $display("FAIL sequential[%0d]: got pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d want pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d",
                            i, o.pc, o.ins, o.p4, o.v, o.h, o.cnt, e.pc, e.ins, e.p4, e.v, e.h, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_stall();
    stim_t s[$];
    exp_t o, e;
    for (int k = 0; k < 3; k++)
      s.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h8, 32'h2009_0002, 32'h8, 1, 0, 32'd2));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'hC, 32'h200A_0003, 32'hC, 1, 0, 32'd3));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].e); tick();
      o = observe(); e = sb.pop_front(); total++;
      if (o !== e) $display("FAIL stall[%0d]: got pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d want pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d",
                            i, o.pc, o.ins, o.p4, o.v, o.h, o.cnt, e.pc, e.ins, e.p4, e.v, e.h, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_redirect();
    stim_t s[$];
    exp_t o, e;
    s.push_back(mk(1, 1, 1, 1, 0, 32'h42, 32'h100, 32'h40, 32'h0, 32'h0, 0, 0, 32'd3));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h44, 32'h2018_0011, 32'h44, 1, 0, 32'd4));
    s.push_back(mk(1, 0, 0, 1, 0, 0, 32'h103, 32'h100, 32'h0, 32'h0, 0, 0, 32'd4));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h104, 32'h2048_0041, 32'h104, 1, 0, 32'd5));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].e); tick();
      o = observe(); e = sb.pop_front(); total++;
      if (o !== e) $display("FAIL redirect[%0d]: got pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d want pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d",
                            i, o.pc, o.ins, o.p4, o.v, o.h, o.cnt, e.pc, e.ins, e.p4, e.v, e.h, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_syscall_halt();
    stim_t s[$];
    exp_t o, e;
    s.push_back(mk(1, 0, 0, 1, 0, 0, 32'h10, 32'h10, 32'h0, 32'h0, 0, 0, 32'd5));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h14, 32'h0000_000C, 32'h14, 1, 1, 32'd6));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h14, 32'h0, 32'h14, 0, 1, 32'd6));
    s.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h14, 32'h0, 32'h14, 0, 1, 32'd6));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h14, 32'h0, 32'h14, 0, 1, 32'd6));
    s.push_back(mk(1, 0, 0, 1, 0, 0, 32'h20, 32'h20, 32'h0, 32'h0, 0, 0, 32'd6));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h24, 32'h2010_0009, 32'h24, 1, 0, 32'd7));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].e); tick();
      o = observe(); e = sb.pop_front(); total++;
      if (o !== e) $display("FAIL syscall_halt[%0d]: got pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d want pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d",
                            i, o.pc, o.ins, o.p4, o.v, o.h, o.cnt, e.pc, e.ins, e.p4, e.v, e.h, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_wrongpath_syscall();
    stim_t s[$];
    exp_t o, e;
    s.push_back(mk(1, 0, 1, 0, 1, 32'h80, 0, 32'h80, 32'h0, 32'h0, 0, 0, 32'd7));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h84, 32'h2028_0021, 32'h84, 1, 0, 32'd8));
    s.push_back(mk(1, 1, 0, 0, 1, 0, 0, 32'h84, 32'h2028_0021, 32'h84, 1, 0, 32'd8));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h88, 32'h2029_0022, 32'h88, 1, 0, 32'd9));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].e); tick();
      o = observe(); e = sb.pop_front(); total++;
      if (o !== e) $display("FAIL wrongpath_syscall[%0d]: got pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d want pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d",
                            i, o.pc, o.ins, o.p4, o.v, o.h, o.cnt, e.pc, e.ins, e.p4, e.v, e.h, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_pc_wrap();
    stim_t s[$];
    exp_t o, e;
    s.push_back(mk(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 32'd9));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, prog(32'hFFFF_FFFC), 32'h0, 1, 0, 32'd10));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h4, 32'h2008_0001, 32'h4, 1, 0, 32'd11));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].e); tick();
      o = observe(); e = sb.pop_front(); total++;
      if (o !== e) $display("FAIL pc_wrap[%0d]: got pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d want pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d",
                            i, o.pc, o.ins, o.p4, o.v, o.h, o.cnt, e.pc, e.ins, e.p4, e.v, e.h, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_reset_while_halted();
    stim_t s[$];
    exp_t o, e;
    s.push_back(mk(1, 0, 0, 1, 0, 0, 32'h10, 32'h10, 32'h0, 32'h0, 0, 0, 32'd11));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h14, 32'h0000_000C, 32'h14, 1, 1, 32'd12));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'd0));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h4, 32'h2008_0001, 32'h4, 1, 0, 32'd1));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].e); tick();
      o = observe(); e = sb.pop_front(); total++;
      if (o !== e) $display("FAIL reset_while_halted[%0d]: got pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d want pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d",
                            i, o.pc, o.ins, o.p4, o.v, o.h, o.cnt, e.pc, e.ins, e.p4, e.v, e.h, e.cnt);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0; r_force_sys = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_syscall_halt();
    test_wrongpath_syscall();
    test_pc_wrap();
    test_reset_while_halted();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Front end of the MIPS pipeline. Owns the program counter, drives the byte address into the instruction memory (a combinational, word-indexed read), and captures the returned instruction into the IF/ID pipeline register for the decoder. Handles stall, branch/jump redirect with flush, and a halt on `syscall`, and counts retired fetches for bring-up.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `HALT_ON_SYSCALL`, default 1: 1 = a fetched `syscall` stops fetch; 0 = `syscall` is treated as an ordinary instruction.
- Reset is synchronous and active-low; the block runs on one clock.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `imem_pc`  out  32  byte address to the instruction memory; equals the PC register.
- `imem_instruction`  in  32  instruction word returned combinationally for `imem_pc`.
- `stall`  in  1  hazard unit hold request.
- `branch_taken`  in  1  taken-branch redirect from a later stage.
- `branch_target`  in  32  branch target byte address.
- `jump`  in  1  jump redirect.
- `jump_target`  in  32  jump target byte address.
- `if_id_instruction`  out  32  registered instruction; 32'h0 (nop) when the slot holds a bubble.
- `if_id_pc_plus4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID slot holds a real instruction.
- `halted`  out  1  fetch is stopped on a `syscall`.
- `fetch_count`  out  32  number of valid captures into IF/ID.

## Operation
- States: RUN, HALTED. `halted` = (state == HALTED).
- Reset (`rst_n`=0 at an edge): PC=`RESET_PC`, `if_id_instruction`=0, `if_id_pc_plus4`=0, `if_id_valid`=0, state=RUN, `fetch_count`=0. Reset overrides every other input.
- Per-edge priority, highest first:
  1. Redirect (`branch_taken` or `jump`):
     - PC = target with bits [1:0] forced to 0.
     - If both are asserted, `branch_target` wins.
     - IF/ID flushed: valid=0, instruction=0, pc_plus4=0.
     - State = RUN. This applies even in HALTED, because the `syscall` was wrong-path.
     - Overrides `stall`. `fetch_count` unchanged.
  2. `stall`: PC, IF/ID, state, and `fetch_count` all hold.
  3. HALTED: PC holds. IF/ID gets a bubble (valid=0, instruction=0).
  4. RUN:
     - IF/ID = {`imem_instruction`, PC+4, valid=1}.
     - PC = PC+4, wrapping modulo 2^32.
     - `fetch_count` += 1, wrapping modulo 2^32.
     - If `HALT_ON_SYSCALL`=1 and `imem_instruction`[31:26]==0 and [5:0]==6'h0C, the `syscall` is still captured valid and state goes to HALTED.
- A `syscall` presented in a redirect cycle or a stall cycle is not captured and causes no halt.
- PC+4 arithmetic is unsigned 32-bit with no carry-out. Out-of-range addresses are the memory's concern; no fault is raised.

## Timing
- `imem_pc` is a register output, with no combinational path from any input.
- Fetch latency: the instruction at PC p is visible in IF/ID one edge after p appears on `imem_pc`.
- Redirect asserted in cycle n:
  - After edge n, `imem_pc` = target and IF/ID = bubble.
  - After edge n+1, IF/ID holds the target instruction.
  - Penalty is one bubble.
- Halt: after the edge that captures `syscall` at PC s, `halted`=1, `imem_pc`=s+4, and `if_id_pc_plus4`=s+4. The following edges produce bubbles until a redirect or reset.
- `fetch_count` is updated on the same edge as the capture it counts.

## Test plan
- Reset with `RESET_PC`=0; program words 0x20080001, 0x20090002, ... -> `imem_pc` steps 0,4,8; IF/ID holds 0x20080001/pc_plus4=4 after the first edge; `fetch_count`=3 after three edges; all outputs 0 during reset.
- `stall` held for 3 cycles at PC=8 -> `imem_pc` stays 8, IF/ID frozen, `fetch_count` frozen; fetch resumes with 8 on release.
- `branch_taken`=1, `branch_target`=0x0000_0042, together with `jump`=1, `jump_target`=0x100, and `stall`=1 -> PC=0x40, IF/ID bubble (valid=0, instruction=0), count unchanged; next edge captures mem[0x40].
- `syscall` (0x0000000C) at PC 0x10 -> captured valid with pc_plus4=0x14, `halted`=1, `imem_pc`=0x14, bubbles afterwards; then `jump`=1 to 0x20 -> `halted`=0 and fetch from 0x20.
- `syscall` present on `imem_instruction` in the same cycle as `branch_taken` -> no halt, no capture, PC=target.
- PC=0xFFFF_FFFC, RUN -> PC wraps to 0, pc_plus4=0; `fetch_count` preset via 2^32-1 captures (or forced) wraps to 0; `rst_n`=0 mid-halt -> all outputs return to their reset values.
